// File: rtl/ifft_16_4.sv
// ---------------------------------------------------------------------------
// ifft_16_4 : 16-point inverse FFT built from the forward fft core through
//             ifft(X) = conj(fft(conj(X))) / 16.
//
// Ports
//   clk          in   clock, rising edge
//   rst_async_n  in   asynchronous active-low reset
//   i_valid      in   i_data holds a 16-bin block (Q8.4, re/im)
//   i_data       in   bins [16][2], element 0 real, element 1 imaginary
//   i_ready      out  block accepted on an edge with i_valid && i_ready
//   o_valid      out  o_data holds 4 time samples (Q1.7)
//   o_data       out  samples 4k..4k+3, [4][2] re/im
//   o_idx        out  group index k
//   o_last       out  high with the final group (k = 3)
//
// Also contains fft: combinational N-point forward DFT core, unnormalised,
// twiddles in Q1.14 with a single rounding of each accumulated output.
// ---------------------------------------------------------------------------

module fft #(
    parameter int N = 16,
    parameter int W = 20
) (
    input  logic signed [W-1:0] i_re [N],
    input  logic signed [W-1:0] i_im [N],
    output logic signed [W-1:0] o_re [N],
    output logic signed [W-1:0] o_im [N]
);
    localparam int ACC_W = W + 21;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(8192);

    // cos(2*pi*idx/16) in Q1.14; sine is the same table shifted by a quarter turn
    function automatic logic signed [15:0] f_cos(input int idx);
        logic signed [15:0] v;
        case (idx % 16)
            0:       v = 16'sd16384;
            1:       v = 16'sd15137;
            2:       v = 16'sd11585;
            3:       v = 16'sd6270;
            4:       v = 16'sd0;
            5:       v = -16'sd6270;
            6:       v = -16'sd11585;
            7:       v = -16'sd15137;
            8:       v = -16'sd16384;
            9:       v = -16'sd15137;
            10:      v = -16'sd11585;
            11:      v = -16'sd6270;
            12:      v = 16'sd0;
            13:      v = 16'sd6270;
            14:      v = 16'sd11585;
            default: v = 16'sd15137;
        endcase
        return v;
    endfunction

    always_comb begin
        logic signed [ACC_W-1:0] v_re;
        logic signed [ACC_W-1:0] v_im;
        logic signed [15:0]      v_c;
        logic signed [15:0]      v_s;
        int                      v_t;
        v_re = '0;
        v_im = '0;
        v_c  = '0;
        v_s  = '0;
        v_t  = 0;
        for (int k = 0; k < N; k++) begin
            v_re = '0;
            v_im = '0;
            for (int n = 0; n < N; n++) begin
                v_t  = ((n * k * 16) / N) % 16;
                v_c  = f_cos(v_t);
                v_s  = f_cos((v_t + 12) % 16);
                // (xr + j xi)(cos - j sin)
                v_re = v_re + ACC_W'(i_re[n]) * ACC_W'(v_c) + ACC_W'(i_im[n]) * ACC_W'(v_s);
                v_im = v_im + ACC_W'(i_im[n]) * ACC_W'(v_c) - ACC_W'(i_re[n]) * ACC_W'(v_s);
            end
            o_re[k] = W'((v_re + RND) >>> 14);
            o_im[k] = W'((v_im + RND) >>> 14);
        end
    end
endmodule

// state  | meaning
// IDLE   | waiting for a block, i_ready = 1
// CALC   | fft result scaled into buffer, group 0 loaded
// STREAM | presenting groups; last group cycle (r_k = 0) is ready again
module ifft_16_4 #(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_async_n,
    input  logic                           i_valid,
    input  logic signed [INPUT_WIDTH-1:0]  i_data [16][2],
    output logic                           i_ready,
    output logic                           o_valid,
    output logic signed [OUTPUT_WIDTH-1:0] o_data [4][2],
    output logic [1:0]                     o_idx,
    output logic                           o_last
);
    localparam int GW = INPUT_WIDTH + 8;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam logic signed [GW:0] SAT_HI = (GW+1)'(2**(OUTPUT_WIDTH-1) - 1);
    localparam logic signed [GW:0] SAT_LO = -(GW+1)'(2**(OUTPUT_WIDTH-1));

    logic [1:0]                     r_state;
    logic [1:0]                     r_k;
    logic signed [GW-1:0]           r_in_re  [16];
    logic signed [GW-1:0]           r_in_im  [16];
    logic signed [OUTPUT_WIDTH-1:0] r_buf_re [16];
    logic signed [OUTPUT_WIDTH-1:0] r_buf_im [16];
    logic signed [GW-1:0]           w_fft_re [16];
    logic signed [GW-1:0]           w_fft_im [16];
    logic signed [OUTPUT_WIDTH-1:0] w_y_re   [16];
    logic signed [OUTPUT_WIDTH-1:0] w_y_im   [16];
    logic                           w_accept;

    function automatic logic signed [OUTPUT_WIDTH-1:0] f_sat(input logic signed [GW:0] v);
        if (v > SAT_HI)
            return OUTPUT_WIDTH'(SAT_HI);
        else if (v < SAT_LO)
            return OUTPUT_WIDTH'(SAT_LO);
        else
            return OUTPUT_WIDTH'(v);
    endfunction

    fft #(.N(16), .W(GW)) u_fft (
        .i_re (r_in_re),
        .i_im (r_in_im),
        .o_re (w_fft_re),
        .o_im (w_fft_im)
    );

    // Shift by 1 folds the /16 and the Q.4 -> Q.7 rescale; the output
    // conjugate is applied before the shift so floor rounding follows it.
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            w_y_re[n] = f_sat((GW+1)'(w_fft_re[n]) >>> 1);
            w_y_im[n] = f_sat((-((GW+1)'(w_fft_im[n]))) >>> 1);
        end
    end

    // r_k wraps to 0 once group 3 is loaded, so r_k = 0 in STREAM marks
    // the cycle presenting the final group.
    assign i_ready  = (r_state == S_IDLE) || ((r_state == S_STREAM) && (r_k == 2'd0));
    assign w_accept = i_valid && i_ready;

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_idx   <= 2'd0;
            for (int l = 0; l < 4; l++) begin
                o_data[l][0] <= '0;
                o_data[l][1] <= '0;
            end
            for (int n = 0; n < 16; n++) begin
                r_in_re[n]  <= '0;
                r_in_im[n]  <= '0;
                r_buf_re[n] <= '0;
                r_buf_im[n] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int n = 0; n < 16; n++) begin
                    r_in_re[n] <= GW'(i_data[n][0]);
                    r_in_im[n] <= -GW'(i_data[n][1]);
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept)
                        r_state <= S_CALC;
                end
                S_CALC: begin
                    for (int n = 0; n < 16; n++) begin
                        r_buf_re[n] <= w_y_re[n];
                        r_buf_im[n] <= w_y_im[n];
                    end
                    for (int l = 0; l < 4; l++) begin
                        o_data[l][0] <= w_y_re[l];
                        o_data[l][1] <= w_y_im[l];
                    end
                    o_valid <= 1'b1;
                    o_idx   <= 2'd0;
                    o_last  <= 1'b0;
                    r_k     <= 2'd1;
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (r_k != 2'd0) begin
                        for (int l = 0; l < 4; l++) begin
                            o_data[l][0] <= r_buf_re[{r_k, 2'(l)}];
                            o_data[l][1] <= r_buf_im[{r_k, 2'(l)}];
                        end
                        o_idx  <= r_k;
                        o_last <= (r_k == 2'd3);
                        r_k    <= r_k + 2'd1;
                    end else begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        r_state <= w_accept ? S_CALC : S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
